fm_demod: RTL and testbench

- FM quadrature discriminator; sits directly downstream of the complex channel FIR.
- Pops one I/Q pair per sample from the FIR's real/imag output FIFOs and multiplies the sample by the conjugate of the previous sample.
- Takes the phase with a quantized arctan approximation, scales it by a demod gain, and pushes one 32-bit audio-rate sample to a single output FIFO.
- Division uses a multi-cycle iterative divider; no combinational divide.

---
 rtl/fm_demod_if.sv | 31 +++
 rtl/fm_demod.sv | 147 ++++++++++++++
 tb/tb_fm_demod.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_demod_if.sv
// ============================================================================
// Module  : fm_demod_if
// Purpose : FIFO-side handshake bundle for the FM quadrature discriminator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fm_demod_if;
  logic signed [31:0] i_in;
  logic signed [31:0] q_in;
  logic               i_rd_en;
  logic               q_rd_en;
  logic               i_empty;
  logic               q_empty;
  logic signed [31:0] demod_out;
  logic               demod_wr_en;
  logic               demod_full;

  // master: the FIFO environment around the demodulator
  modport master (
    output i_in, q_in, i_empty, q_empty, demod_full,
    input  i_rd_en, q_rd_en, demod_out, demod_wr_en
  );

  modport slave (
    input  i_in, q_in, i_empty, q_empty, demod_full,
    output i_rd_en, q_rd_en, demod_out, demod_wr_en
  );
endinterface

`default_nettype wire

// File: rtl/fm_demod.sv
// ============================================================================
// Module  : fm_demod
// Purpose : FM quadrature discriminator: conjugate product, quantized arctan
//           with a 32-cycle restoring divider, demod gain, one output FIFO push.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fm_demod #(
  parameter int                 BITS  = 10,
  parameter logic signed [31:0] QUAD1 = 32'sd804,
  parameter logic signed [31:0] QUAD3 = 32'sd2412,
  parameter logic signed [31:0] GAIN  = 32'sd758
) (
  input  wire logic  clock,
  input  wire logic  reset,
  fm_demod_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_SETUP = 3'd2,
    S_DIV   = 3'd3,
    S_ANGLE = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t             r_state;
  logic signed [31:0] r_x, r_y;
  logic signed [31:0] r_prev_real, r_prev_imag;
  logic signed [31:0] r_r, r_i;
  logic               r_r_neg, r_i_neg, r_q_neg;
  logic        [31:0] r_quo, r_den, r_rem;
  logic        [4:0]  r_cnt;
  logic signed [31:0] r_demod_out;

  logic               w_pop, w_push;
  logic signed [31:0] w_ay, w_num, w_den;
  logic        [32:0] w_rem_sh, w_rem_sub;
  logic signed [31:0] w_q, w_angle_raw, w_angle;

  function automatic logic signed [31:0] deq_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [31:0] p;
    p = a * b;
    return p >>> BITS;
  endfunction

  // Reset gates the combinational strobes so nothing is popped or pushed while held.
  assign w_pop  = reset && (r_state == S_IDLE) && !bus.i_empty && !bus.q_empty;
  assign w_push = reset && (r_state == S_OUT) && !bus.demod_full;

  assign bus.i_rd_en     = w_pop;
  assign bus.q_rd_en     = w_pop;
  assign bus.demod_wr_en = w_push;
  assign bus.demod_out   = r_demod_out;

  always_comb begin
    w_ay = (r_i[31] ? -r_i : r_i) + 32'sd1;
    if (!r_r[31]) begin
      w_num = (r_r - w_ay) <<< BITS;
      w_den = r_r + w_ay;
    end else begin
      w_num = (r_r + w_ay) <<< BITS;
      w_den = w_ay - r_r;
    end
  end

  // Bit 32 of the trial subtraction set means the shifted remainder is below the divisor.
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_den};

  always_comb begin
    w_q         = r_q_neg ? -$signed(r_quo) : $signed(r_quo);
    w_angle_raw = (r_r_neg ? QUAD3 : QUAD1) - deq_mul(QUAD1, w_q);
    w_angle     = r_i_neg ? -w_angle_raw : w_angle_raw;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_prev_real <= '0;
      r_prev_imag <= '0;
      r_r         <= '0;
      r_i         <= '0;
      r_r_neg     <= 1'b0;
      r_i_neg     <= 1'b0;
      r_q_neg     <= 1'b0;
      r_quo       <= '0;
      r_den       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_demod_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_x     <= bus.i_in;
            r_y     <= bus.q_in;
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          r_r         <= deq_mul(r_prev_real, r_x) + deq_mul(r_prev_imag, r_y);
          r_i         <= deq_mul(r_prev_real, r_y) - deq_mul(r_prev_imag, r_x);
          r_prev_real <= r_x;
          r_prev_imag <= r_y;
          r_state     <= S_SETUP;
        end
        S_SETUP: begin
          r_r_neg <= r_r[31];
          r_i_neg <= r_i[31];
          r_quo   <= w_num[31] ? $unsigned(-w_num) : $unsigned(w_num);
          r_den   <= w_den[31] ? $unsigned(-w_den) : $unsigned(w_den);
          r_q_neg <= w_num[31] ^ w_den[31];
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= S_DIV;
        end
        S_DIV: begin
          r_rem <= w_rem_sub[32] ? w_rem_sh[31:0] : w_rem_sub[31:0];
          r_quo <= {r_quo[30:0], ~w_rem_sub[32]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_ANGLE;
          end
        end
        S_ANGLE: begin
          r_demod_out <= deq_mul(GAIN, w_angle);
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (w_push) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fm_demod.sv
// ============================================================================
// Module  : tb_fm_demod
// Purpose : Directed and randomized check of fm_demod against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fm_demod;
  logic clock = 1'b0;
  logic reset = 1'b0;

  fm_demod_if bus ();

  fm_demod dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pops   = 0;
  int n_writes = 0;
  int fi[$], fq[$];
  int exp_q[$];
  int wr_val[$], wr_cyc[$], pop_cyc[$];
  bit pop_i = 1'b0, pop_q = 1'b0;
  int m_pr = 0, m_pi = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: the discriminator written as plain integer arithmetic.
  function automatic int deq(input int v);
    return v >>> 10;
  endfunction

  function automatic int model_out(input int pr, input int pi, input int x, input int y);
    int r, i, ay, num, den, q, angle;
    r  = deq(pr * x) + deq(pi * y);
    i  = deq(pr * y) - deq(pi * x);
    ay = ((i < 0) ? -i : i) + 1;
    if (r >= 0) begin
      num = (r - ay) * 1024; den = r + ay; angle = 804;
    end else begin
      num = (r + ay) * 1024; den = ay - r; angle = 2412;
    end
    q     = num / den;
    angle = angle - deq(804 * q);
    if (i < 0) angle = -angle;
    return deq(758 * angle);
  endfunction

  task automatic check(input string tag, input int got, input int expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  // Observe strobes mid-cycle, where the DUT's combinational outputs are settled.
  always @(negedge clock) begin
    if (bus.i_rd_en || bus.q_rd_en) begin
      n_assert++;
      assert (bus.i_rd_en === bus.q_rd_en) else begin
        n_fail++;
        $error("FAIL rd_en_pair: observed i=%0b q=%0b expected equal", bus.i_rd_en, bus.q_rd_en);
      end
      pop_i = bus.i_rd_en;
      pop_q = bus.q_rd_en;
      n_pops++;
      pop_cyc.push_back(cyc);
    end
    if (bus.demod_wr_en) begin
      n_assert++;
      assert (bus.demod_full === 1'b0) else begin
        n_fail++;
        $error("FAIL wr_while_full: observed full=%0b expected 0", bus.demod_full);
      end
      n_writes++;
      wr_val.push_back(bus.demod_out);
      wr_cyc.push_back(cyc);
    end
  end

  // First-word-fall-through FIFO emulation for I and Q.
  initial begin
    bus.i_in = 0; bus.q_in = 0; bus.i_empty = 1'b1; bus.q_empty = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (pop_i && fi.size() > 0) void'(fi.pop_front());
      if (pop_q && fq.size() > 0) void'(fq.pop_front());
      pop_i = 1'b0;
      pop_q = 1'b0;
      bus.i_empty = (fi.size() == 0);
      bus.q_empty = (fq.size() == 0);
      bus.i_in    = (fi.size() > 0) ? fi[0] : 0;
      bus.q_in    = (fq.size() > 0) ? fq[0] : 0;
    end
  end

  task automatic push(input int x, input int y);
    fi.push_back(x);
    fq.push_back(y);
    exp_q.push_back(model_out(m_pr, m_pi, x, y));
    m_pr = x;
    m_pi = y;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    tick(1);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    m_pr = 0; m_pi = 0;
    exp_q.delete(); pop_cyc.delete(); wr_val.delete(); wr_cyc.delete();
  endtask

  task automatic wait_write(input string tag, input int budget, output int val, output int wc);
    int k = 0;
    while (wr_val.size() == 0 && k < budget) begin
      tick(1);
      k++;
    end
    n_assert++;
    assert (wr_val.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed no write, expected one within %0d cycles", tag, budget);
    end
    val = 0; wc = -1;
    if (wr_val.size() != 0) begin
      val = wr_val.pop_front();
      wc  = wr_cyc.pop_front();
    end
  endtask

  task automatic expect_next(input string tag, output int wc);
    int v, e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    wait_write(tag, 200, v, wc);
    check(tag, v, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v, wc, pc, p0, w0, k, x, y;
    bus.demod_full = 1'b0;

    // Held in reset with a sample waiting: nothing may move.
    push(1024, 0);
    tick(3);
    check("reset_demod_out", bus.demod_out, 0);
    check("reset_wr_en", int'(bus.demod_wr_en), 0);
    check("reset_rd_en", int'(bus.i_rd_en), 0);
    check("reset_no_pop", n_pops, 0);

    reset = 1'b1;
    void'(exp_q.pop_front());
    wait_write("t1_write", 100, v, wc);
    check("t1_value", v, 1190);
    pc = (pop_cyc.size() > 0) ? pop_cyc.pop_front() : -100;
    check("t1_latency", wc - pc, 36);
    tick(10);
    check("t1_single_write", n_writes, 1);

    push(0, -1024);
    void'(exp_q.pop_front());
    wait_write("t3_write", 100, v, wc);
    check("t3_value", v, -1191);
    pc = (pop_cyc.size() > 0) ? pop_cyc.pop_front() : -100;
    check("t3_latency", wc - pc, 36);

    do_reset();
    push(1024, 0);
    push(1024, 0);
    expect_next("t2_first", wc);
    expect_next("t2_second", wc);
    check("t2_pop_count", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) check("t2_throughput", pop_cyc[1] - pop_cyc[0], 37);

    do_reset();
    push(1024, 0);
    push(-1024, 0);
    expect_next("t4_first", wc);
    expect_next("t4_second", wc);

    // Output FIFO full while three samples wait.
    pop_cyc.delete();
    bus.demod_full = 1'b1;
    p0 = n_pops; w0 = n_writes;
    push(700, -300);
    push(512, 512);
    push(-900, 100);
    tick(50);
    check("full_pops", n_pops - p0, 1);
    check("full_writes", n_writes - w0, 0);
    check("full_wr_en", int'(bus.demod_wr_en), 0);
    check("full_held_out", bus.demod_out, exp_q[0]);
    bus.demod_full = 1'b0;
    expect_next("full_release", wc);
    tick(2);
    check("full_pop_count", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) check("full_next_pop", pop_cyc[1] - wc, 1);
    expect_next("full_second", wc);
    expect_next("full_third", wc);

    // Reset in the middle of division: sample discarded, history cleared.
    push(300, 400);
    p0 = n_pops; k = 0;
    while (n_pops == p0 && k < 100) begin tick(1); k++; end
    check("div_popped", n_pops - p0, 1);
    tick(11);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    m_pr = 0; m_pi = 0;
    exp_q.delete();
    w0 = n_writes;
    tick(60);
    check("div_no_write", n_writes - w0, 0);
    wr_val.delete(); wr_cyc.delete();
    push(1024, 0);
    void'(exp_q.pop_front());
    wait_write("div_after", 100, v, wc);
    check("div_after_value", v, 1190);

    // I ready with Q empty: neither FIFO is popped.
    p0 = n_pops;
    fi.push_back(555);
    tick(20);
    check("i_only_no_pop", n_pops - p0, 0);
    fq.push_back(-222);
    exp_q.push_back(model_out(m_pr, m_pi, 555, -222));
    m_pr = 555; m_pi = -222;
    expect_next("i_then_q", wc);

    // Random samples with random output back-pressure.
    for (int n = 0; n < 20; n++) begin
      x = int'($urandom_range(8191)) - 4096;
      y = int'($urandom_range(8191)) - 4096;
      push(x, y);
    end
    k = 0;
    while (exp_q.size() > 0 && k < 3000) begin
      tick(1);
      k++;
      bus.demod_full = ($urandom_range(3) == 0);
      while (wr_val.size() > 0 && exp_q.size() > 0) begin
        check("rand_value", wr_val.pop_front(), exp_q.pop_front());
        void'(wr_cyc.pop_front());
      end
    end
    check("rand_drained", exp_q.size(), 0);
    bus.demod_full = 1'b0;
    tick(60);
    check("rand_no_extra", wr_val.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
